// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction buffer: circular store with lane compaction,
// duplicate-PC suppression and a multi-lane head window for decode.
module fetch_buffer #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned DEC_WIDTH   = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [FETCH_WIDTH-1:0]            in_valid,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] in_pc,
  input  logic [FETCH_WIDTH*32-1:0]         in_instr,
  input  logic [FETCH_WIDTH-1:0]            in_guesses_branch,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] in_prediction,
  output logic                              in_ready,
  output logic [DEC_WIDTH-1:0]              out_valid,
  output logic [DEC_WIDTH*ADDR_WIDTH-1:0]   out_pc,
  output logic [DEC_WIDTH*32-1:0]           out_instr,
  output logic [DEC_WIDTH-1:0]              out_guesses_branch,
  output logic [DEC_WIDTH*ADDR_WIDTH-1:0]   out_prediction,
  input  logic                              out_ready,
  input  logic                              flush,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [31:0]           instr_mem[DEPTH];
  logic                  gb_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] pred_mem [DEPTH];

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] last_pc_q, last_pc_d;
  logic                  last_pc_valid_q, last_pc_valid_d;

  logic [FETCH_WIDTH-1:0] acc;
  logic [PTR_W-1:0]       slot_off [FETCH_WIDTH];
  logic [CNT_W-1:0]       acc_n, deq_n;
  logic [ADDR_WIDTH-1:0]  hi_pc;

  assign count    = count_q;
  assign in_ready = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));

  // A lane survives only if it differs from the previous group's last PC and
  // from every lower lane already accepted; survivors pack from the tail.
  always_comb begin
    acc   = '0;
    acc_n = '0;
    hi_pc = last_pc_q;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      slot_off[i] = acc_n[PTR_W-1:0];
      if (in_ready && !flush && in_valid[i]) begin
        acc[i] = 1'b1;
        if (last_pc_valid_q && (in_pc[i*ADDR_WIDTH +: ADDR_WIDTH] == last_pc_q))
          acc[i] = 1'b0;
        for (int unsigned j = 0; j < i; j++) begin
          if (acc[j] && (in_pc[j*ADDR_WIDTH +: ADDR_WIDTH] == in_pc[i*ADDR_WIDTH +: ADDR_WIDTH]))
            acc[i] = 1'b0;
        end
      end
      if (acc[i]) begin
        acc_n = acc_n + CNT_W'(1);
        hi_pc = in_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    out_valid          = '0;
    out_pc             = '0;
    out_instr          = '0;
    out_guesses_branch = '0;
    out_prediction     = '0;
    for (int unsigned i = 0; i < DEC_WIDTH; i++) begin
      out_valid[i]                              = (count_q > CNT_W'(i));
      out_pc[i*ADDR_WIDTH +: ADDR_WIDTH]         = pc_mem[head_q + PTR_W'(i)];
      out_instr[i*32 +: 32]                      = instr_mem[head_q + PTR_W'(i)];
      out_guesses_branch[i]                      = gb_mem[head_q + PTR_W'(i)];
      out_prediction[i*ADDR_WIDTH +: ADDR_WIDTH] = pred_mem[head_q + PTR_W'(i)];
    end
  end

  always_comb begin
    deq_n = '0;
    if (out_ready) begin
      for (int unsigned i = 0; i < DEC_WIDTH; i++) begin
        if (out_valid[i]) deq_n = deq_n + CNT_W'(1);
      end
    end
  end

  always_comb begin
    head_d          = head_q + deq_n[PTR_W-1:0];
    tail_d          = tail_q + acc_n[PTR_W-1:0];
    count_d         = count_q + acc_n - deq_n;
    last_pc_d       = last_pc_q;
    last_pc_valid_d = last_pc_valid_q;
    if (acc_n != '0) begin
      last_pc_d       = hi_pc;
      last_pc_valid_d = 1'b1;
    end
    if (flush) begin
      head_d          = '0;
      tail_d          = '0;
      count_d         = '0;
      last_pc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      last_pc_q       <= '0;
      last_pc_valid_q <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      last_pc_q       <= last_pc_d;
      last_pc_valid_q <= last_pc_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (!reset && acc[i]) begin
        pc_mem   [tail_q + slot_off[i]] <= in_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
        instr_mem[tail_q + slot_off[i]] <= in_instr[i*32 +: 32];
        gb_mem   [tail_q + slot_off[i]] <= in_guesses_branch[i];
        pred_mem [tail_q + slot_off[i]] <= in_prediction[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with default parameters (2 lanes, depth 8).
module tb_fetch_buffer;

  logic        clk;
  logic        reset;
  logic [1:0]  in_valid;
  logic [63:0] in_pc;
  logic [63:0] in_instr;
  logic [1:0]  in_guesses_branch;
  logic [63:0] in_prediction;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_instr;
  logic [1:0]  out_guesses_branch;
  logic [63:0] out_prediction;
  logic        out_ready;
  logic        flush;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_buffer #(.FETCH_WIDTH(2), .DEC_WIDTH(2), .DEPTH(8), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_guesses_branch(in_guesses_branch), .in_prediction(in_prediction),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_guesses_branch(out_guesses_branch), .out_prediction(out_prediction),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction word and prediction are derived from the PC so fields can be checked.
  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    in_valid          = v;
    in_pc             = {p1, p0};
    in_instr          = {16'hC0DE, p1[15:0], 16'hC0DE, p0[15:0]};
    in_guesses_branch = {p1[2], p0[2]};
    in_prediction     = {p1 + 32'h40, p0 + 32'h40};
  endtask

  task automatic idle();
    in_valid = 2'b00;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
  endtask

  task automatic test_basic();
    drive(2'b11, 32'h100, 32'h104);
    step();
    idle();
    total++; if (count !== 4'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", count); end
    total++; if (out_valid !== 2'b11) begin bad++; $display("FAIL basic_out_valid got=%b exp=11", out_valid); end
    total++; if (out_pc[31:0] !== 32'h100) begin bad++; $display("FAIL basic_pc0 got=%h exp=100", out_pc[31:0]); end
    total++; if (out_pc[63:32] !== 32'h104) begin bad++; $display("FAIL basic_pc1 got=%h exp=104", out_pc[63:32]); end
    total++; if (out_instr[63:32] !== 32'hC0DE0104) begin bad++; $display("FAIL basic_instr1 got=%h exp=c0de0104", out_instr[63:32]); end
    total++; if (out_prediction[31:0] !== 32'h140) begin bad++; $display("FAIL basic_pred0 got=%h exp=140", out_prediction[31:0]); end
    total++; if (out_guesses_branch !== 2'b10) begin bad++; $display("FAIL basic_gb got=%b exp=10", out_guesses_branch); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL basic_drain got=%0d exp=0", count); end
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL basic_drain_valid got=%b exp=00", out_valid); end
  endtask

  task automatic test_compaction();
    drive(2'b10, 32'h1F0, 32'h200);
    step();
    idle();
    total++; if (count !== 4'd1) begin bad++; $display("FAIL comp_count got=%0d exp=1", count); end
    total++; if (out_valid !== 2'b01) begin bad++; $display("FAIL comp_out_valid got=%b exp=01", out_valid); end
    total++; if (out_pc[31:0] !== 32'h200) begin bad++; $display("FAIL comp_pc0 got=%h exp=200", out_pc[31:0]); end
    total++; if (out_instr[31:0] !== 32'hC0DE0200) begin bad++; $display("FAIL comp_instr0 got=%h exp=c0de0200", out_instr[31:0]); end
    drain();
  endtask

  task automatic test_dup();
    drive(2'b11, 32'h300, 32'h304);
    step();
    total++; if (count !== 4'd2) begin bad++; $display("FAIL dup_first got=%0d exp=2", count); end
    step();
    total++; if (count !== 4'd3) begin bad++; $display("FAIL dup_repeat got=%0d exp=3", count); end
    drive(2'b11, 32'h400, 32'h400);
    step();
    total++; if (count !== 4'd4) begin bad++; $display("FAIL dup_samegroup got=%0d exp=4", count); end
    step();
    idle();
    total++; if (count !== 4'd4) begin bad++; $display("FAIL dup_alldropped got=%0d exp=4", count); end
    total++; if (out_pc !== {32'h304, 32'h300}) begin bad++; $display("FAIL dup_head got=%h exp=00000304_00000300", out_pc); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (count !== 4'd2) begin bad++; $display("FAIL dup_deq_count got=%0d exp=2", count); end
    total++; if (out_pc !== {32'h400, 32'h300}) begin bad++; $display("FAIL dup_order got=%h exp=00000400_00000300", out_pc); end
    drain();
  endtask

  task automatic test_full();
    drive(2'b11, 32'h700, 32'h704); step();
    drive(2'b11, 32'h708, 32'h70C); step();
    drive(2'b11, 32'h710, 32'h714); step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready6 got=%b exp=1", in_ready); end
    drive(2'b01, 32'h718, 32'h0); step();
    total++; if (count !== 4'd7) begin bad++; $display("FAIL full_count7 got=%0d exp=7", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready7 got=%b exp=0", in_ready); end
    drive(2'b11, 32'h720, 32'h724); step();
    total++; if (count !== 4'd7) begin bad++; $display("FAIL full_ignored got=%0d exp=7", count); end
    total++; if (out_pc[31:0] !== 32'h700) begin bad++; $display("FAIL full_head got=%h exp=700", out_pc[31:0]); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total++; if (count !== 4'd5) begin bad++; $display("FAIL full_deq got=%0d exp=5", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready5 got=%b exp=1", in_ready); end
    step();
    total++; if (count !== 4'd7) begin bad++; $display("FAIL full_refill got=%0d exp=7", count); end
    total++; if (out_pc[31:0] !== 32'h708) begin bad++; $display("FAIL full_head2 got=%h exp=708", out_pc[31:0]); end
    idle(); out_ready = 1'b1; step();
    drive(2'b01, 32'h728, 32'h0); step();
    idle(); out_ready = 1'b0;
    total++; if (count !== 4'd4) begin bad++; $display("FAIL full_mixed got=%0d exp=4", count); end
    total++; if (out_pc[31:0] !== 32'h718) begin bad++; $display("FAIL full_mixed_head got=%h exp=718", out_pc[31:0]); end
    drain();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      base = 32'h1000 + 32'(k) * 32'd8;
      drive(2'b11, base, base + 32'd4);
      step();
      total++; if (count !== 4'd2) begin bad++; $display("FAIL b2b_count k=%0d got=%0d exp=2", k, count); end
      total++; if (out_pc !== {base + 32'd4, base}) begin bad++; $display("FAIL b2b_pc k=%0d got=%h exp=%h", k, out_pc, {base + 32'd4, base}); end
    end
    out_ready = 1'b0;
    drain();
  endtask

  task automatic test_flush();
    drive(2'b11, 32'h500, 32'h504); step();
    drive(2'b11, 32'h508, 32'h50C); step();
    drive(2'b11, 32'h300, 32'h304); step();
    total++; if (count !== 4'd6) begin bad++; $display("FAIL flush_pre got=%0d exp=6", count); end
    drive(2'b11, 32'h600, 32'h604);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0; idle();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL flush_out_valid got=%b exp=00", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    drive(2'b01, 32'h304, 32'h0); step(); idle();
    total++; if (count !== 4'd1) begin bad++; $display("FAIL flush_reenq got=%0d exp=1", count); end
    total++; if (out_pc[31:0] !== 32'h304) begin bad++; $display("FAIL flush_reenq_pc got=%h exp=304", out_pc[31:0]); end
    step();
    total++; if (count !== 4'd1) begin bad++; $display("FAIL flush_hold got=%0d exp=1", count); end
    drain();
  endtask

  task automatic test_reset_mid();
    drive(2'b11, 32'h800, 32'h804); step();
    drive(2'b11, 32'h808, 32'h80C); step();
    total++; if (count !== 4'd4) begin bad++; $display("FAIL rmid_pre got=%0d exp=4", count); end
    drive(2'b11, 32'h810, 32'h814);
    reset = 1'b1;
    step();
    reset = 1'b0; idle();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL rmid_out_valid got=%b exp=00", out_valid); end
    drive(2'b01, 32'h80C, 32'h0); step(); idle();
    total++; if (count !== 4'd1) begin bad++; $display("FAIL rmid_lastpc got=%0d exp=1", count); end
    total++; if (out_pc[31:0] !== 32'h80C) begin bad++; $display("FAIL rmid_pc got=%h exp=80c", out_pc[31:0]); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    test_reset();
    test_basic();
    test_compaction();
    test_dup();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter FETCH_WIDTH, default 2, meaning instruction lanes written per cycle by fetch.
REQ-002 Parameter DEC_WIDTH, default 2, meaning instruction lanes presented per cycle to decode.
REQ-003 Parameter DEPTH, default 8, meaning entry count; power of two and >= FETCH_WIDTH + DEC_WIDTH.
REQ-004 Parameter ADDR_WIDTH, default 32, meaning PC width.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  FETCH_WIDTH  per-lane valid from fetch.
REQ-008 in_pc  input  FETCH_WIDTH*ADDR_WIDTH  lane PCs; lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 in_instr  input  FETCH_WIDTH*32  lane instruction words.
REQ-010 in_guesses_branch  input  FETCH_WIDTH  lane predicted-taken flag.
REQ-011 in_prediction  input  FETCH_WIDTH*ADDR_WIDTH  lane predicted next PC.
REQ-012 in_ready  output  1  buffer accepts a fetch group this cycle.
REQ-013 out_valid  output  DEC_WIDTH  per-lane valid to decode; always contiguous from lane 0.
REQ-014 out_pc, out_instr, out_guesses_branch, out_prediction  output  DEC_WIDTH-wide packed, same lane layout as inputs  head entries.
REQ-015 out_ready  input  1  decode consumes all asserted out_valid lanes this cycle.
REQ-016 flush  input  1  discard all contents (redirect).
REQ-017 count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-018 Storage: circular buffer, head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH with no gap.
REQ-019 in_ready = (DEPTH - count >= FETCH_WIDTH), from current count only; same-cycle dequeue does not raise it.
REQ-020 Enqueue fires when in_ready && |in_valid; invalid lanes skipped; accepted lanes written to consecutive slots from tail in ascending lane order (compaction).
REQ-021 Duplicate suppression: a valid lane is dropped when its PC equals last_pc while last_pc_valid=1, or equals the PC of a lower accepted lane in the same group.
REQ-022 last_pc/last_pc_valid update on every enqueue to the PC of the highest accepted lane; unchanged when no lane is accepted.
REQ-023 in_valid with in_ready=0: no write, no state change, last_pc unchanged; upstream must hold.
REQ-024 out_valid[i] = (count > i); out fields combinationally from entry (head+i) mod DEPTH; enqueue-to-out_valid latency 1 cycle.
REQ-025 Dequeue when out_ready: head advances by popcount(out_valid), count decreases by the same amount; out_ready with count=0 is a no-op.
REQ-026 Simultaneous enqueue and dequeue: count_next = count + accepted - dequeued in one cycle.
REQ-027 flush has priority over enqueue and dequeue: next cycle count=0, head=tail=0, last_pc_valid=0, out_valid=0; the same-cycle fetch group is discarded.
REQ-028 count never exceeds DEPTH; no underflow.

Reset
REQ-029 reset has priority over flush and all traffic; takes effect on the next posedge.
REQ-030 Reset values: count=0, head=tail=0, last_pc_valid=0, last_pc=0, out_valid=0, in_ready=1; entry contents need not be cleared.
REQ-031 reset asserted mid-operation discards all entries exactly as flush does.

Verification
REQ-032 Reset, then in_valid=2'b11, PCs 0x100/0x104 -> next cycle count=2, out_valid=2'b11, out_pc lane0=0x100, lane1=0x104.
REQ-033 in_valid=2'b10, lane1 PC 0x200 -> entry written at tail; out lane0 PC=0x200, count=1 (compaction).
REQ-034 Enqueue 0x300/0x304, then the same group again -> 0x304 dropped, 0x300 accepted; count +3 total. Group 0x400/0x400 -> one entry.
REQ-035 Fill to count=7 with out_ready=0 -> in_ready=0; in_valid ignored; out_ready=1 for one cycle -> count=5, in_ready=1; run 20+ groups for pointer wrap, order preserved.
REQ-036 count=6, same cycle enqueue 2, out_ready=1, flush=1 -> next cycle count=0, out_valid=0, last_pc_valid=0; then PC 0x304 re-enqueues without suppression.
REQ-037 count=4, assert reset for one cycle with in_valid=2'b11 -> count=0, in_ready=1, out_valid=0.
